// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, SR/Cause field positions and exception codes.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam logic [31:0] PRID_VALUE = 32'h2023_0707;

  localparam int SR_IE       = 0;
  localparam int SR_EXL      = 1;
  localparam int SR_IM_LO    = 8;
  localparam int CAUSE_BD    = 31;
  localparam int CAUSE_IP_LO = 8;
  localparam int CAUSE_EXC_LO = 2;
  localparam int MAX_HWINT   = 6;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // EPC is always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer; raises a sticky interrupt when Count meets a non-zero Compare.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_ip
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count    <= '0;
      compare  <= '0;
      timer_ip <= 1'b0;
    end else begin
      count <= wr_count ? wdata : count + 32'd1;
      // Writing Compare acknowledges the timer interrupt.
      if (wr_compare) begin
        compare  <= wdata;
        timer_ip <= 1'b0;
      end else if ((count == compare) && (compare != 32'd0)) begin
        timer_ip <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_unit.sv
// CP0 coprocessor: SR/Cause/EPC/PRId, interrupt and exception entry, eret support.
// Optional Count/Compare timer is built only when CP0_TIMER_EN is defined.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT  = 6,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [4:0]           cp0_addr,
  input  logic [31:0]          cp0_wdata,
  input  logic [31:0]          vpc,
  input  logic                 bd_in,
  input  logic [4:0]           exc_code_in,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic                 exl_clr,
  output logic [31:0]          cp0_rdata,
  output logic [31:0]          epc_out,
  output logic                 req,
  output logic [31:0]          handler_pc
);

  logic        ie_reg;
  logic        exl_reg;
  logic [7:0]  im_reg;
  logic        bd_reg;
  logic [5:0]  hw_ip_reg;
  logic [4:0]  exc_code_reg;
  logic [31:0] epc_reg;

  logic [5:0]  hw_vec;
  logic [7:0]  ip_now;
  logic [7:0]  ip_eval;
  logic        int_req;
  logic        exc_req;
  logic        wr_en;
  logic        timer_ip;
  logic [31:0] count_val;
  logic [31:0] compare_val;

  generate
    for (genvar gi = 0; gi < MAX_HWINT; gi++) begin : g_hw
      if (gi < NUM_HWINT) begin : g_used
        assign hw_vec[gi] = hw_int[gi];
      end else begin : g_tied
        assign hw_vec[gi] = 1'b0;
      end
    end
  endgenerate

  assign ip_now  = {hw_ip_reg, 1'b0, timer_ip};
  // Live interrupt lines are ORed in so a newly raised line is taken this cycle.
  assign ip_eval = ip_now | {hw_vec, 2'b00};
  assign int_req = !exl_reg && ie_reg && |(ip_eval & im_reg);
  assign exc_req = !exl_reg && (exc_code_in != EXC_INT);
  assign req     = int_req | exc_req;
  assign wr_en   = en && !req;

  assign handler_pc = HANDLER_PC;
  assign epc_out    = (en && (cp0_addr == CP0_EPC)) ? word_align(cp0_wdata) : epc_reg;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .wr_count   (wr_en && (cp0_addr == CP0_COUNT)),
    .wr_compare (wr_en && (cp0_addr == CP0_COMPARE)),
    .wdata      (cp0_wdata),
    .count      (count_val),
    .compare    (compare_val),
    .timer_ip   (timer_ip)
  );
`else
  assign timer_ip    = 1'b0;
  assign count_val   = 32'd0;
  assign compare_val = 32'd0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      ie_reg       <= 1'b0;
      exl_reg      <= 1'b0;
      im_reg       <= '0;
      bd_reg       <= 1'b0;
      hw_ip_reg    <= '0;
      exc_code_reg <= '0;
      epc_reg      <= '0;
    end else begin
      hw_ip_reg <= hw_vec;
      if (req) begin
        exl_reg      <= 1'b1;
        bd_reg       <= bd_in;
        exc_code_reg <= int_req ? EXC_INT : exc_code_in;
        epc_reg      <= bd_in ? vpc - 32'd4 : vpc;
      end else begin
        if (wr_en && (cp0_addr == CP0_SR)) begin
          ie_reg  <= cp0_wdata[SR_IE];
          exl_reg <= cp0_wdata[SR_EXL];
          im_reg  <= cp0_wdata[SR_IM_LO +: 8];
        end
        if (exl_clr) exl_reg <= 1'b0;
        if (wr_en && (cp0_addr == CP0_EPC)) epc_reg <= word_align(cp0_wdata);
      end
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_SR: begin
        cp0_rdata[SR_IE]           = ie_reg;
        cp0_rdata[SR_EXL]          = exl_reg;
        cp0_rdata[SR_IM_LO +: 8]   = im_reg;
      end
      CP0_CAUSE: begin
        cp0_rdata[CAUSE_BD]          = bd_reg;
        cp0_rdata[CAUSE_IP_LO +: 8]  = ip_now;
        cp0_rdata[CAUSE_EXC_LO +: 5] = exc_code_reg;
      end
      CP0_EPC:     cp0_rdata = epc_reg;
      CP0_PRID:    cp0_rdata = PRID_VALUE;
      CP0_COUNT:   cp0_rdata = count_val;
      CP0_COMPARE: cp0_rdata = compare_val;
      default:     cp0_rdata = '0;
    endcase
  end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have parameter NUM_HWINT, default 6, meaning number of external interrupt lines (legal range 1..6).
REQ-002 SHALL have parameter HANDLER_PC, default 32'h0000_4180, meaning the exception/interrupt entry address.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset: reset==0 at a rising clk edge resets.
REQ-005 SHALL have ports en in 1 (mtc0 write enable), cp0_addr in 5 (register number), cp0_wdata in 32 (mtc0 data).
REQ-006 SHALL have ports vpc in 32 (victim PC of the M-stage instruction), bd_in in 1 (in delay slot), exc_code_in in 5 (0 = no exception).
REQ-007 SHALL have ports hw_int in NUM_HWINT (level-sensitive external interrupts) and exl_clr in 1 (eret in M stage).
REQ-008 SHALL have outputs cp0_rdata 32 (mfc0 data), epc_out 32 (eret target), req 1 (flush/redirect request) and handler_pc 32 (constant HANDLER_PC).

Function
REQ-009 SHALL implement registers SR(12), Cause(13), EPC(14), PRId(15, read-only constant 32'h2023_0707), Count(9), Compare(11); other addresses read 0 and ignore writes.
REQ-010 SHALL hold SR fields IE=bit0, EXL=bit1, IM=bits[15:8]; unimplemented bits read 0 and are not writable.
REQ-011 SHALL hold Cause fields BD=bit31, IP=bits[15:8], ExcCode=bits[6:2]; Cause is not writable by mtc0.
REQ-012 SHALL latch Cause.IP[10+i] <= hw_int[i] every cycle for i < NUM_HWINT; IP bits above 10+NUM_HWINT-1 read 0.
REQ-013 SHALL compute, combinationally, int_req = !EXL & IE & |(IP & IM), evaluated on the next-cycle IP value (hw_int ORed in), and exc_req = !EXL & (exc_code_in != 0).
REQ-014 SHALL drive req = int_req | exc_req; interrupt has priority: ExcCode <= 0 when int_req, else exc_code_in.
REQ-015 SHALL on req at the clock edge set EXL <= 1, Cause.BD <= bd_in, EPC <= bd_in ? vpc-4 : vpc.
REQ-016 SHALL suppress the mtc0 write when req and en coincide.
REQ-017 SHALL clear EXL on exl_clr; if req and exl_clr coincide, req wins and EXL stays 1.
REQ-018 SHALL write EPC via mtc0 with bits[1:0] forced to 0.
REQ-019 SHALL drive epc_out = cp0_wdata&~3 when en & cp0_addr==14 in the same cycle (bypass), else the EPC register.
REQ-020 SHALL drive cp0_rdata combinationally from cp0_addr, showing the registered values.

Reset
REQ-021 SHALL on reset clear SR, Cause, EPC, Count and Compare to 0; req = 0 and epc_out = 0 in the cycle after reset.
REQ-022 SHALL give reset priority over req, en and exl_clr in the same cycle.

Configuration
REQ-023 SHALL compile the internal timer only when CP0_TIMER_EN is defined.
REQ-024 With CP0_TIMER_EN: Count increments by 1 every non-reset cycle, wrapping 32'hFFFF_FFFF -> 0, and is writable via mtc0; on Count==Compare with Compare!=0, Cause.IP[8] is set and held; any mtc0 to Compare clears IP[8].
REQ-025 Without CP0_TIMER_EN: Count and Compare read 0, writes to them are ignored, and IP[8] is constant 0.

Structure
REQ-026 SHALL take register numbers, SR/Cause bit positions and EXC_* codes from the shared constants file; no local duplicates.
REQ-027 SHALL place the timer in one sub-module, cp0_timer, instantiated only under CP0_TIMER_EN.

Verification
REQ-028 Interrupt: SR=32'h0000_0401, hw_int[0]=1 -> req=1 that cycle; next cycle EXL=1, ExcCode=0, EPC=vpc, req=0.
REQ-029 Delay slot: exc_code_in=12 (Ov), bd_in=1, vpc=32'h3010 -> EPC=32'h300C, Cause.BD=1, ExcCode=12.
REQ-030 Masked: IE=0, hw_int=all 1 -> req stays 0, Cause.IP[15:10] reads 6'b111111; exception code 10 with IE=0 -> req=1.
REQ-031 Collision: req with en=1 to SR -> SR write dropped; req with exl_clr -> EXL=1; mtc0 EPC=32'h3007 with exl_clr -> epc_out=32'h3004 same cycle.
REQ-032 Timer (CP0_TIMER_EN): Compare=5 after reset -> IP[8] set once Count reaches 5; with IM[8]=IE=1, req=1; write Compare -> IP[8]=0.
REQ-033 Reset mid-handler: EXL=1, EPC=32'h3000, reset=0 for one edge -> all registers 0, req=0.
